// File: rtl/muldiv_seq.sv
// Multi-cycle MUL/DIV sequencer for the EXE stage: drives ALU phase/strobe controls and the EXE stall.
// Optional divide-by-zero early out is enabled with `define MULDIV_SEQ_DIV_EARLY_OUT_EN.
module muldiv_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_i,
    input  logic       mul_i,
    input  logic       div_i,
    input  logic       divisor_zero_i,
    input  logic       hold_i,
    input  logic       flush_i,
    output logic [1:0] mul_state_o,
    output logic       d_init_o,
    output logic       d_advance_o,
    output logic       div_last_o,
    output logic       stall_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MUL1     = 3'd1,
        MUL2     = 3'd2,
        DIV_ITER = 3'd3,
        DIV_DONE = 3'd4
    } state_t;

    state_t     state_reg, state_next;
    logic [4:0] cnt_reg, cnt_next;
    logic       done_rep_reg;
    logic       start;
    logic       div_zero;

`ifdef MULDIV_SEQ_DIV_EARLY_OUT_EN
    assign div_zero = divisor_zero_i;
`else
    assign div_zero = 1'b0;
    logic  unused_divisor_zero;
    assign unused_divisor_zero = divisor_zero_i;
`endif

    assign start  = valid_i & (mul_i | div_i) & ~flush_i;
    assign busy_o = (state_reg != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= 5'd0;
            done_rep_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            // Marks repeated DIV_DONE cycles so the divider is advanced only once while held.
            done_rep_reg <= (state_reg == DIV_DONE) && (state_next == DIV_DONE);
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        mul_state_o = 2'b00;
        d_init_o    = 1'b0;
        d_advance_o = 1'b0;
        div_last_o  = 1'b0;
        stall_o     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    stall_o = 1'b1;
                    if (div_i) begin
                        d_init_o   = 1'b1;
                        cnt_next   = 5'd0;
                        state_next = div_zero ? DIV_DONE : DIV_ITER;
                    end else begin
                        mul_state_o = 2'b01;
                        state_next  = MUL1;
                    end
                end
            end
            MUL1: begin
                mul_state_o = 2'b10;
                stall_o     = 1'b1;
                state_next  = MUL2;
            end
            MUL2: begin
                mul_state_o = 2'b11;
                if (!hold_i) state_next = IDLE;
            end
            DIV_ITER: begin
                d_advance_o = 1'b1;
                stall_o     = 1'b1;
                cnt_next    = cnt_reg + 5'd1;
                if (cnt_reg == 5'd30) state_next = DIV_DONE;
            end
            DIV_DONE: begin
                div_last_o  = 1'b1;
                d_advance_o = ~done_rep_reg;
                if (!hold_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (flush_i) begin
            mul_state_o = 2'b00;
            d_init_o    = 1'b0;
            d_advance_o = 1'b0;
            div_last_o  = 1'b0;
            stall_o     = 1'b0;
            state_next  = IDLE;
            cnt_next    = 5'd0;
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected per-cycle output vectors are queued at drive time
// and compared at the following falling edge.
module tb_muldiv_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_i, mul_i, div_i, divisor_zero_i, hold_i, flush_i;
    logic [1:0] mul_state_o;
    logic       d_init_o, d_advance_o, div_last_o, stall_o, busy_o;
    logic [6:0] outs;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    logic [6:0] exp_q[$];

    muldiv_seq dut (
        .clk            (clk),
        .reset          (reset),
        .valid_i        (valid_i),
        .mul_i          (mul_i),
        .div_i          (div_i),
        .divisor_zero_i (divisor_zero_i),
        .hold_i         (hold_i),
        .flush_i        (flush_i),
        .mul_state_o    (mul_state_o),
        .d_init_o       (d_init_o),
        .d_advance_o    (d_advance_o),
        .div_last_o     (div_last_o),
        .stall_o        (stall_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    // {mul_state, d_init, d_advance, div_last, stall, busy}
    assign outs = {mul_state_o, d_init_o, d_advance_o, div_last_o, stall_o, busy_o};

    function automatic logic [6:0] pk(input logic [1:0] ms, input logic i, input logic a,
                                      input logic l, input logic s, input logic b);
        return {ms, i, a, l, s, b};
    endfunction

    task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got ms/init/adv/last/stall/busy=%b required %b", tag, got, exp);
    endtask

    task automatic drive_cycle(input string tag, input logic v, input logic m, input logic d,
                               input logic dz, input logic h, input logic f,
                               input logic [6:0] exp);
        @(posedge clk);
        #1;
        valid_i = v; mul_i = m; div_i = d; divisor_zero_i = dz; hold_i = h; flush_i = f;
        exp_q.push_back(exp);
        @(negedge clk);
        check_eq(tag, outs, exp_q.pop_front());
    endtask

    task automatic idle_cycle(input string tag);
        drive_cycle(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
    endtask

    task automatic run_mul(input int hold_n);
        logic [6:0] e;
        for (int k = 0; k <= 2 + hold_n; k++) begin
            if (k == 0)      e = pk(2'b01, 0, 0, 0, 1, 0);
            else if (k == 1) e = pk(2'b10, 0, 0, 0, 1, 1);
            else             e = pk(2'b11, 0, 0, 0, 0, 1);
            drive_cycle($sformatf("mul h=%0d k=%0d", hold_n, k), 1'b1, 1'b1, 1'b0, 1'b0,
                        (k >= 2) && (k < 2 + hold_n), 1'b0, e);
        end
        $display("mul hold=%0d issued, %0d cycles", hold_n, 3 + hold_n);
    endtask

    task automatic run_div(input int hold_n, input logic both, input logic dz);
        logic [6:0] e;
        for (int k = 0; k <= 32 + hold_n; k++) begin
            if (k == 0)       e = pk(2'b00, 1, 0, 0, 1, 0);
            else if (k < 32)  e = pk(2'b00, 0, 1, 0, 1, 1);
            else if (k == 32) e = pk(2'b00, 0, 1, 1, 0, 1);
            else              e = pk(2'b00, 0, 0, 1, 0, 1);
            drive_cycle($sformatf("div h=%0d k=%0d", hold_n, k), 1'b1, both, 1'b1, dz,
                        (k >= 32) && (k < 32 + hold_n), 1'b0, e);
        end
        $display("div hold=%0d both=%0b dz=%0b issued, %0d cycles", hold_n, both, dz, 33 + hold_n);
    endtask

    initial begin
        reset = 1'b1;
        valid_i = 0; mul_i = 0; div_i = 0; divisor_zero_i = 0; hold_i = 0; flush_i = 0;
        #12;
        check_eq("reset state", outs, 7'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        idle_cycle("idle after reset");

        run_mul(0);
        run_mul(2);
        idle_cycle("idle after mul");
        run_div(0, 1'b0, 1'b0);
        run_div(3, 1'b0, 1'b0);
        run_div(0, 1'b1, 1'b0);
        idle_cycle("idle after div");

        // Flushed issue in IDLE must not start anything.
        drive_cycle("flush idle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'd0);
        idle_cycle("idle after flush");

        // Flush at DIV_ITER cycle 10.
        for (int k = 0; k <= 10; k++) begin
            drive_cycle($sformatf("div flush k=%0d", k), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, k == 10,
                        (k == 0)  ? pk(2'b00, 1, 0, 0, 1, 0) :
                        (k == 10) ? pk(2'b00, 0, 0, 0, 0, 1) : pk(2'b00, 0, 1, 0, 1, 1));
        end
        for (int k = 0; k < 4; k++) idle_cycle($sformatf("post flush k=%0d", k));
        $display("div flushed at iteration cycle 10");

        // Asynchronous reset while in MUL1.
        drive_cycle("rst mul k=0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, pk(2'b01, 0, 0, 0, 1, 0));
        @(posedge clk);
        #1;
        check_eq("rst mul1 before", outs, pk(2'b10, 0, 0, 0, 1, 1));
        #1;
        valid_i = 0; mul_i = 0;
        reset = 1'b1;
        #1;
        check_eq("rst mul1 async", outs, 7'd0);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("rst mul1 after", outs, 7'd0);
        idle_cycle("idle after rst");
        run_mul(0);
        $display("mul aborted by reset, then reissued");

`ifdef MULDIV_SEQ_DIV_EARLY_OUT_EN
        drive_cycle("div0 k=0", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, pk(2'b00, 1, 0, 0, 1, 0));
        drive_cycle("div0 k=1", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, pk(2'b00, 0, 1, 1, 0, 1));
        $display("div by zero early out, 2 cycles");
`else
        run_div(0, 1'b0, 1'b1);
`endif
        idle_cycle("final idle");
        idle_cycle("final idle 2");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 valid_i  input  1  EXE-stage instruction valid (not a bubble).
REQ-004 mul_i  input  1  EXE instruction is MUL/MULH/MULHSU/MULHU.
REQ-005 div_i  input  1  EXE instruction is DIV/DIVU/REM/REMU.
REQ-006 divisor_zero_i  input  1  rs2 operand equals zero; used only when DIV_EARLY_OUT_EN is defined.
REQ-007 hold_i  input  1  downstream (MEM) stall; EXE result cannot leave this cycle.
REQ-008 flush_i  input  1  EXE flush (redirection or exception).
REQ-009 mul_state_o  output  2  multiplier phase select to ALU.
REQ-010 d_init_o  output  1  divider load strobe to ALU.
REQ-011 d_advance_o  output  1  divider iterate strobe to ALU.
REQ-012 div_last_o  output  1  final divider iteration; quotient/remainder valid on ALU output.
REQ-013 stall_o  output  1  EXE stall request; drives st_e.
REQ-014 busy_o  output  1  sequencer not in IDLE.

Function
REQ-015 States: IDLE, MUL1, MUL2, DIV_ITER, DIV_DONE; 5-bit iteration counter cnt.
REQ-016 start = valid_i & (mul_i | div_i) & ~flush_i, evaluated only in IDLE; mul_i and div_i both high is treated as div.
REQ-017 IDLE, start mul: mul_state_o=01, stall_o=1; next state MUL1.
REQ-018 MUL1: mul_state_o=10, stall_o=1; next state MUL2.
REQ-019 MUL2: mul_state_o=11, stall_o=0; next state IDLE, or stays MUL2 while hold_i=1 (outputs unchanged).
REQ-020 Multiply latency: 3 cycles from issue to result; stall_o high for exactly 2 cycles when hold_i=0.
REQ-021 IDLE, start div: d_init_o=1, stall_o=1, cnt<=0; next state DIV_ITER.
REQ-022 DIV_ITER: d_advance_o=1, stall_o=1, cnt<=cnt+1; when cnt==30 next state DIV_DONE.
REQ-023 DIV_DONE: d_advance_o=1, div_last_o=1, stall_o=0 in its first cycle; next state IDLE.
REQ-024 DIV_DONE with hold_i=1: remains in DIV_DONE, div_last_o=1, d_advance_o=0 on repeated cycles, stall_o=0, so divider state is not advanced twice.
REQ-025 Divide latency: 33 cycles (1 init + 31 iterate + 1 last); stall_o high for 32 cycles when hold_i=0.
REQ-026 In IDLE with no start: all strobes 0, mul_state_o=00, stall_o=0, busy_o=0.
REQ-027 flush_i=1 in any state: all strobes, mul_state_o and stall_o forced 0 combinationally that cycle; next state IDLE, cnt<=0.
REQ-028 Strobes are mutually exclusive except d_advance_o with div_last_o; mul_state_o!=00 never coincides with a divider strobe.
REQ-029 Counter never wraps: cnt saturates logically because DIV_ITER exits at cnt==30.
REQ-030 A new operation is accepted only from IDLE; back-to-back operations incur one IDLE cycle (the issue cycle of the next op).

Reset
REQ-031 reset asserted: state<=IDLE, cnt<=0 immediately, independent of clk.
REQ-032 During and after reset until first start: mul_state_o=00, d_init_o=d_advance_o=div_last_o=0, stall_o=0, busy_o=0.
REQ-033 reset mid-operation abandons the operation; no completion strobe is produced.

Configuration
REQ-034 Macro MULDIV_SEQ_DIV_EARLY_OUT_EN.
REQ-035 Defined: IDLE div start with divisor_zero_i=1 asserts d_init_o, stall_o=1, then goes directly to DIV_DONE; divide latency 2 cycles, d_advance_o never asserted in DIV_ITER.
REQ-036 Undefined: divisor_zero_i ignored; all divides take 33 cycles.

Verification
REQ-037 Mul issue, hold_i=0 -> mul_state_o 01,10,11 on cycles 0,1,2; stall_o 1,1,0; back to IDLE cycle 3.
REQ-038 Div issue, divisor 7 -> d_init_o cycle 0; d_advance_o cycles 1-32; div_last_o cycle 32 only; stall_o high cycles 0-31.
REQ-039 Div with hold_i=1 for 3 cycles at DIV_DONE -> div_last_o high 4 cycles, d_advance_o high only first of them.
REQ-040 flush_i at DIV_ITER cycle 10 -> strobes 0 that cycle, busy_o=0 next cycle, no div_last_o ever.
REQ-041 reset pulse at MUL1 -> outputs 0 asynchronously; subsequent mul completes normally in 3 cycles.
REQ-042 Macro defined, divisor_zero_i=1 -> d_init_o cycle 0, div_last_o cycle 1, stall_o 1,0; macro undefined same stimulus -> 33-cycle sequence.
